// File: rtl/piped_alu.sv
// rtl/piped_alu.sv - two-stage valid/ready ALU with add/sub, nand, xor and shift units
//
// Purpose
//   Accepts one operand/command beat per cycle. Stage S1 registers the
//   operands and command. Stage S2 computes the selected function and
//   registers the result and the Z/N/V flags. Both stages use valid/ready
//   handshakes, so back-to-back beats stream with no bubbles. Back-pressure
//   from out_ready stalls S2 first, then S1.
//
// Optional feature (macro PIPED_ALU_SAT_EN)
//   When defined, add/sub results that overflow saturate to the most
//   positive or most negative value. V still reports the overflow.
//   When undefined, add/sub wraps modulo 2^WIDTH.
//
// Parameters
//   WIDTH      datapath width in bits (8, 16, 32 or 64)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand/command beat present
//   in_ready   beat accepted this cycle
//   a, b       operands; b[SHW-1:0] is the shift amount for shift ops
//   op         00 add/sub, 01 nand, 10 xor, 11 shift
//   sub        with op=00: 0 A+B, 1 A-B
//   shmode     with op=11: 00 sll, 01 srl, 10 sra, 11 ror
//   out_valid  result beat present
//   out_ready  downstream accepts the result beat
//   result     registered result
//   flag_z     result was zero (every S2 load)
//   flag_n     sign of the last add/sub result
//   flag_v     signed overflow of the last add/sub

module piped_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             sub,
  input  logic [1:0]       shmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_NAND  = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // S1 stage registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_op;
  logic             s1_sub;
  logic [1:0]       s1_shmode;

  // Handshake controls
  logic s1_load;
  logic s2_load;

  // S2 combinational datapath
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   sum;
  logic               ovf;
  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   alu_res;

  // S2 can take a new beat whenever its output slot is empty or being
  // drained this cycle; S1 can then refill in the same cycle, which is what
  // gives one beat per cycle while out_ready stays high.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= OP_ADD;
      s1_sub    <= 1'b0;
      s1_shmode <= SH_SLL;
    end else begin
      if (s1_load) begin
        s1_valid  <= 1'b1;
        s1_a      <= a;
        s1_b      <= b;
        s1_op     <= op;
        s1_sub    <= sub;
        s1_shmode <= shmode;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    // A-B is formed as A + ~B + 1 so a single adder serves both.
    b_eff = s1_sub ? ~s1_b : s1_b;
    sum   = s1_a + b_eff + {{(WIDTH-1){1'b0}}, s1_sub};
    // With B already conditionally inverted, add and sub share one rule:
    // equal operand signs and a result sign that differs from A.
    ovf   = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
    amt   = s1_b[SHW-1:0];
    // Rotate via a doubled word: the low half after shifting is A rotated.
    rot   = {s1_a, s1_a} >> amt;

    alu_res = '0;
    case (s1_op)
      OP_ADD: begin
`ifdef PIPED_ALU_SAT_EN
        // Overflow direction follows A's sign: a positive A can only
        // overflow upwards, a negative A only downwards.
        if (ovf) begin
          alu_res = s1_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          alu_res = sum;
        end
`else
        alu_res = sum;
`endif
      end
      OP_NAND: alu_res = ~(s1_a & s1_b);
      OP_XOR:  alu_res = s1_a ^ s1_b;
      OP_SHIFT: begin
        case (s1_shmode)
          SH_SLL:  alu_res = s1_a << amt;
          SH_SRL:  alu_res = s1_a >> amt;
          SH_SRA:  alu_res = $unsigned($signed(s1_a) >>> amt);
          SH_ROR:  alu_res = rot[WIDTH-1:0];
          default: alu_res = s1_a;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // S2 stage: result and flags move together on the loading edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        flag_z    <= (alu_res == '0);
        // N and V describe the most recent arithmetic op only.
        if (s1_op == OP_ADD) begin
          flag_n <= alu_res[WIDTH-1];
          flag_v <= ovf;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/piped_alu.md
PIPED_ALU -- requirements
Module: piped_alu

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Localparam SHW, equal to clog2(WIDTH): shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand/command beat present.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount for shift ops.
REQ-009 op  input  2  unit select: 00 add/sub, 01 nand, 10 xor, 11 shift.
REQ-010 sub  input  1  when op=00: 0 selects A+B, 1 selects A-B.
REQ-011 shmode  input  2  when op=11: 00 sll, 01 srl, 10 sra, 11 ror.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result beat.
REQ-014 result  output  WIDTH  registered result.
REQ-015 flag_z, flag_n, flag_v  output  1 each  registered flags.

Function
REQ-016 The datapath SHALL have two stages: S1 registers a, b, op, sub and shmode; S2 computes and registers result and flags.
- Latency: out_valid asserts 2 cycles after an in_valid&&in_ready edge.
REQ-017 S2 SHALL load when s1_valid && (!out_valid || out_ready); S1 SHALL load when in_valid && in_ready.
REQ-018 in_ready SHALL equal !s1_valid || (!out_valid || out_ready), giving full-throughput streaming (one beat per cycle) with no bubbles.
REQ-019 Under out_valid && !out_ready, result, flags and out_valid SHALL hold; S1 holds; in_ready deasserts once S1 is occupied.
REQ-020 When S2 loads and S1 empties on the same edge with no new input, s1_valid SHALL clear; when S2 drains and nothing loads, out_valid SHALL clear.
REQ-021 Add/sub SHALL be WIDTH-bit two's complement; A-B = A + ~B + 1.
REQ-022 V SHALL be set on signed overflow: add — operands have equal sign and the sum's sign differs; sub — operands have different sign and the result's sign differs from A.
REQ-023 Nand SHALL produce ~(A&B); xor SHALL produce A^B.
REQ-024 Shift amount SHALL be b[SHW-1:0]; an amount of 0 passes A unchanged.
- sra replicates A[WIDTH-1].
- ror rotates right modulo WIDTH.
REQ-025 Z flag SHALL be 1 exactly when the S2 result equals 0; it updates on every S2 load.
REQ-026 N and V SHALL update only on S2 loads with op=00; other ops hold N and V.
- N = result[WIDTH-1].
REQ-027 Flags SHALL change only on the edge that loads S2, in lockstep with result.

Reset
REQ-028 Asserting rst SHALL immediately and asynchronously clear s1_valid, out_valid, result, flag_z, flag_n and flag_v to 0.
REQ-029 Reset asserted mid-stream SHALL discard in-flight beats; no beat accepted before reset appears afterwards.
REQ-030 in_ready SHALL be 1 from the first edge after rst deasserts.

Configuration
REQ-031 With macro PIPED_ALU_SAT_EN defined, add/sub overflow SHALL saturate: positive overflow to 0111..1, negative overflow to 1000..0.
- V still reports the overflow.
- Z and N reflect the saturated value.
REQ-032 Without PIPED_ALU_SAT_EN, add/sub SHALL wrap modulo 2^WIDTH; no saturation logic is present.

Verification
REQ-033 WIDTH=16, add 0x7FFF+0x0001 -> 2 cycles later result=0x8000 N=1 V=1 Z=0; with PIPED_ALU_SAT_EN result=0x7FFF N=0 V=1.
REQ-034 sub 0x1234-0x1234 -> result=0x0000 Z=1 N=0 V=0; a following xor 0x00FF^0x0F0F -> result=0x0FF0 Z=0, N and V unchanged.
REQ-035 Shifts on A=0x8001, b=4 -> sll 0x0010, srl 0x0800, sra 0xF800, ror 0x1800; b=0x0010 (amount 0) -> 0x8001.
REQ-036 Stream 8 beats with out_ready=1 -> 8 results on consecutive cycles, in order; hold out_ready=0 for 3 cycles mid-stream -> result stable, in_ready=0 after S1 fills, no loss or duplication.
REQ-037 Assert rst with both stages full -> out_valid=0, flags=0 immediately; after release the first accepted beat is the first output.
